// File: rtl/spi_frame_reader.sv
// SPI mode-0 slave (MSB first) that streams a stored frame out of SPRAM, framed by a status/command byte.
// Define SPI_FRAME_CRC_EN to append a CRC-16-CCITT trailer after the last frame byte.
module spi_frame_reader #(
  parameter int unsigned FRAME_BYTES = 9600,
  parameter int unsigned ADDR_W      = 17,
  parameter int unsigned SYNC_STAGES = 3,
  parameter int unsigned RD_LATENCY  = 1
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              spi_sck,
  input  logic              spi_mosi,
  input  logic              spi_ncs,
  output logic              spi_miso,
  output logic [ADDR_W-1:0] spram_rd_addr,
  output logic              spram_rd_en,
  input  logic [7:0]        spram_rd_data,
  input  logic              buffer_ready,
  output logic              busy,
  output logic              frame_read_complete,
  output logic              frame_read_abort
);

  localparam int unsigned NEW = SYNC_STAGES - 2;
  localparam int unsigned OLD = SYNC_STAGES - 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_BYTES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_STREAM,
    ST_PAD
`ifdef SPI_FRAME_CRC_EN
    , ST_CRC
`endif
  } state_t;

  logic [SYNC_STAGES-1:0] sck_sync, ncs_sync, mosi_sync;
  logic sck_rise, sck_fall, ncs_on, ncs_off, mosi_bit;

  // Synchronisers; ncs resets inactive so no false assertion edge after reset.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sck_sync  <= '0;
      ncs_sync  <= '1;
      mosi_sync <= '0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], spi_ncs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
    end
  end

  assign sck_rise = sck_sync[NEW] & ~sck_sync[OLD];
  assign sck_fall = ~sck_sync[NEW] & sck_sync[OLD];
  assign ncs_on   = ~ncs_sync[NEW] & ncs_sync[OLD];
  assign ncs_off  = ncs_sync[NEW] & ~ncs_sync[OLD];
  assign mosi_bit = mosi_sync[OLD];

  logic [RD_LATENCY-1:0] lat_pipe;
  logic [7:0]            pf_data;

  // Prefetch register captures SPRAM data exactly RD_LATENCY cycles after the strobe.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      lat_pipe <= '0;
      pf_data  <= '0;
    end else begin
      lat_pipe[0] <= spram_rd_en;
      for (int i = 1; i < int'(RD_LATENCY); i++) lat_pipe[i] <= lat_pipe[i-1];
      if (lat_pipe[RD_LATENCY-1]) pf_data <= spram_rd_data;
    end
  end

`ifdef SPI_FRAME_CRC_EN
  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {d, 8'h00};
    for (int i = 0; i < 8; i++) r = r[15] ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
    return r;
  endfunction

  logic [15:0] crc, crc_nx;
  logic        crc_sel, crc_sel_nx;
`endif

  state_t            state, state_nx;
  logic [7:0]        shift_out, shift_nx;
  logic [2:0]        bit_cnt, bit_nx;
  logic [6:0]        cmd_sr, cmd_nx;
  logic              rdy_l, rdy_nx, ovr, ovr_nx;
  logic [ADDR_W-1:0] byte_idx, idx_nx, addr_nx;
  logic              rd_en_nx, miso_nx, busy_nx, complete_nx, abort_nx;
  logic              byte_end, abort_st;
  logic [7:0]        cmd_full;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state               <= ST_IDLE;
      shift_out           <= '0;
      bit_cnt             <= '0;
      cmd_sr              <= '0;
      rdy_l               <= 1'b0;
      ovr                 <= 1'b0;
      byte_idx            <= '0;
      spram_rd_addr       <= '0;
      spram_rd_en         <= 1'b0;
      spi_miso            <= 1'b0;
      busy                <= 1'b0;
      frame_read_complete <= 1'b0;
      frame_read_abort    <= 1'b0;
`ifdef SPI_FRAME_CRC_EN
      crc                 <= 16'hFFFF;
      crc_sel             <= 1'b0;
`endif
    end else begin
      state               <= state_nx;
      shift_out           <= shift_nx;
      bit_cnt             <= bit_nx;
      cmd_sr              <= cmd_nx;
      rdy_l               <= rdy_nx;
      ovr                 <= ovr_nx;
      byte_idx            <= idx_nx;
      spram_rd_addr       <= addr_nx;
      spram_rd_en         <= rd_en_nx;
      spi_miso            <= miso_nx;
      busy                <= busy_nx;
      frame_read_complete <= complete_nx;
      frame_read_abort    <= abort_nx;
`ifdef SPI_FRAME_CRC_EN
      crc                 <= crc_nx;
      crc_sel             <= crc_sel_nx;
`endif
    end
  end

  // Next-state logic: ncs deassertion has priority over any sck edge.
  always_comb begin
    state_nx    = state;
    shift_nx    = shift_out;
    bit_nx      = bit_cnt;
    cmd_nx      = cmd_sr;
    rdy_nx      = rdy_l;
    ovr_nx      = ovr;
    idx_nx      = byte_idx;
    addr_nx     = spram_rd_addr;
    rd_en_nx    = 1'b0;
    miso_nx     = spi_miso;
    complete_nx = 1'b0;
    abort_nx    = 1'b0;
    cmd_full    = {cmd_sr, mosi_bit};
    byte_end    = sck_rise && (bit_cnt == 3'd7);
    abort_st    = (state == ST_STREAM);
`ifdef SPI_FRAME_CRC_EN
    crc_nx      = crc;
    crc_sel_nx  = crc_sel;
    if (state == ST_CRC) abort_st = 1'b1;
`endif

    if (ncs_off) begin
      state_nx = ST_IDLE;
      miso_nx  = 1'b0;
      addr_nx  = '0;
      bit_nx   = '0;
      abort_nx = abort_st;
      ovr_nx   = abort_st;
    end else if (state == ST_IDLE) begin
      if (ncs_on) begin
        rdy_nx   = buffer_ready;
        miso_nx  = buffer_ready;
        shift_nx = {6'b0, ovr, 1'b0};
        bit_nx   = '0;
        addr_nx  = '0;
        rd_en_nx = 1'b1;
        state_nx = ST_CMD;
`ifdef SPI_FRAME_CRC_EN
        crc_nx     = 16'hFFFF;
        crc_sel_nx = 1'b0;
`endif
      end
    end else begin
      if (sck_fall) begin
        miso_nx  = shift_out[7];
        shift_nx = {shift_out[6:0], 1'b0};
      end
      if (sck_rise) begin
        bit_nx = bit_cnt + 3'd1;
        cmd_nx = {cmd_sr[5:0], mosi_bit};
      end
      if (byte_end) begin
        case (state)
          ST_CMD: begin
            if (cmd_full == 8'h01 && rdy_l) begin
              state_nx = ST_STREAM;
              shift_nx = pf_data;
              idx_nx   = '0;
`ifdef SPI_FRAME_CRC_EN
              crc_nx   = crc_upd(crc, pf_data);
`endif
              if (LAST_ADDR != '0) begin
                addr_nx  = ADDR_W'(1);
                rd_en_nx = 1'b1;
              end
            end else begin
              state_nx = ST_PAD;
              shift_nx = 8'h00;
            end
          end
          ST_STREAM: begin
            if (byte_idx == LAST_ADDR) begin
`ifdef SPI_FRAME_CRC_EN
              state_nx   = ST_CRC;
              shift_nx   = crc[15:8];
              crc_sel_nx = 1'b0;
`else
              state_nx    = ST_PAD;
              shift_nx    = 8'h00;
              complete_nx = 1'b1;
`endif
            end else begin
              shift_nx = pf_data;
              idx_nx   = byte_idx + ADDR_W'(1);
`ifdef SPI_FRAME_CRC_EN
              crc_nx   = crc_upd(crc, pf_data);
`endif
              if (spram_rd_addr != LAST_ADDR) begin
                addr_nx  = spram_rd_addr + ADDR_W'(1);
                rd_en_nx = 1'b1;
              end
            end
          end
`ifdef SPI_FRAME_CRC_EN
          ST_CRC: begin
            if (!crc_sel) begin
              shift_nx   = crc[7:0];
              crc_sel_nx = 1'b1;
            end else begin
              state_nx    = ST_PAD;
              shift_nx    = 8'h00;
              complete_nx = 1'b1;
            end
          end
`endif
          default: shift_nx = 8'h00;
        endcase
      end
    end

    busy_nx = (state_nx != ST_IDLE);
  end

endmodule
